// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the moore_seq_detect slice: the detector state type
// with its 3-bit binary encodings, and the 1011 pattern the FSM looks for.
// No ports (package).
// ---------------------------------------------------------------------------
package seq_det_pkg;

   // One state per length of pattern prefix matched so far.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_1    = 3'd1,
      S_10   = 3'd2,
      S_101  = 3'd3,
      S_1011 = 3'd4
   } state_t;

   // Pattern, oldest bit in the MSB.
   localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating match counter with a sticky threshold flag.
//
// Parameters
//   CNT_W  : counter width
//   THRESH : count value at which flag sets (1 .. 2^CNT_W-1)
// Ports
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   inc    : count one event on this edge
//   clr    : synchronous clear of cnt and flag, wins over inc
//   cnt    : current count, saturates at all-ones
//   flag   : set when cnt becomes THRESH, held until clr or reset
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int CNT_W  = 8,
   parameter int THRESH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             flag
);

   localparam logic [CNT_W-1:0] THR_VAL = THRESH[CNT_W-1:0];
   localparam logic [CNT_W-1:0] MAX_VAL = '1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_flag;
   logic [CNT_W-1:0] w_cntPlusOne;

   assign w_cntPlusOne = r_cnt + 1'b1;

   // Counter and flag update. Clear beats a same-cycle increment. The flag is
   // only ever set by the increment that lands exactly on the threshold, so a
   // saturated counter sitting at the threshold does not re-trigger anything.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt  <= '0;
         r_flag <= 1'b0;
      end else if (clr) begin
         r_cnt  <= '0;
         r_flag <= 1'b0;
      end else if (inc && (r_cnt != MAX_VAL)) begin
         r_cnt <= w_cntPlusOne;
         if (w_cntPlusOne == THR_VAL) begin
            r_flag <= 1'b1;
         end
      end
   end

   assign cnt  = r_cnt;
   assign flag = r_flag;

endmodule

// File: rtl/moore_seq_detect.sv
// ---------------------------------------------------------------------------
// moore_seq_detect
// Moore FSM detecting the overlapping serial pattern 1,0,1,1 on valid bits,
// with an optional saturating match counter and sticky threshold flag.
//
// Configuration macro: MOORE_SEQ_DETECT_CNT_EN
//   defined   -> sat_counter is built and drives match_cnt / thr_flag
//   undefined -> match_cnt and thr_flag are constant 0, clr has no effect
//
// Parameters
//   CNT_W     : width of match_cnt
//   THRESH    : match count at which thr_flag sets
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   in_bit    : serial data bit
//   in_valid  : in_bit is consumed only when high
//   clr       : synchronous clear of match_cnt and thr_flag
//   match     : high while the FSM sits in S_1011
//   match_cnt : matches since reset or clr
//   thr_flag  : sticky threshold-reached flag
// ---------------------------------------------------------------------------
module moore_seq_detect
   import seq_det_pkg::*;
#(
   parameter int CNT_W  = 8,
   parameter int THRESH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_bit,
   input  logic             in_valid,
   input  logic             clr,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             thr_flag
);

   state_t r_state;
   state_t w_nextState;

   // State register. Reset drops any partial pattern, so the first valid bit
   // afterwards is always evaluated from S_IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. Without a valid bit the state holds. On a mismatch the
   // FSM falls back to the longest suffix that is still a pattern prefix,
   // which is what makes back-to-back overlapping detections work.
   always_comb begin
      w_nextState = r_state;
      if (in_valid) begin
         case (r_state)
            S_IDLE:  w_nextState = (in_bit == PATTERN[3]) ? S_1    : S_IDLE;
            S_1:     w_nextState = (in_bit == PATTERN[2]) ? S_10   : S_1;
            S_10:    w_nextState = (in_bit == PATTERN[1]) ? S_101  : S_IDLE;
            S_101:   w_nextState = (in_bit == PATTERN[0]) ? S_1011 : S_10;
            S_1011:  w_nextState = in_bit ? S_1 : S_10;
            default: w_nextState = S_IDLE;
         endcase
      end
   end

   // Moore output straight from the state register.
   assign match = (r_state == S_1011);

`ifdef MOORE_SEQ_DETECT_CNT_EN
   logic w_enterMatch;

   // S_1011 has no self-loop, so every edge that lands there is a new match.
   assign w_enterMatch = in_valid && (w_nextState == S_1011);

   sat_counter #(
      .CNT_W  (CNT_W),
      .THRESH (THRESH)
   ) u_satCounter (
      .clk   (clk),
      .reset (reset),
      .inc   (w_enterMatch),
      .clr   (clr),
      .cnt   (match_cnt),
      .flag  (thr_flag)
   );
`else
   // Counter not built. clr is folded into the constant so the port is still
   // read; thr_flag remains a hard 0.
   assign match_cnt = '0;
   assign thr_flag  = 1'b0 & clr;
`endif

endmodule

// File: tb/tb_moore_seq_detect.sv
// ---------------------------------------------------------------------------
// tb_moore_seq_detect
// Self-checking bench for moore_seq_detect. Two instances share the same
// stimulus: one with default parameters and one with CNT_W=2, THRESH=3 so
// counter saturation is reachable. The reference model keeps the last four
// valid bits and compares them against the pattern directly.
// ---------------------------------------------------------------------------
module tb_moore_seq_detect;

   localparam int THR_A = 4;
   localparam int MAX_A = 255;
   localparam int THR_B = 3;
   localparam int MAX_B = 3;

   logic       clk;
   logic       reset;
   logic       inBit;
   logic       inValid;
   logic       clr;
   logic       matchA;
   logic [7:0] cntA;
   logic       flagA;
   logic       matchB;
   logic [1:0] cntB;
   logic       flagB;

   int compareCount;
   int mismatchCount;

   // Reference model state
   logic [3:0] hist;
   int         nValid;
   logic       expMatch;
   int         mCntA;
   int         mCntB;
   logic       mFlagA;
   logic       mFlagB;

   moore_seq_detect u_dutA (
      .clk       (clk),
      .reset     (reset),
      .in_bit    (inBit),
      .in_valid  (inValid),
      .clr       (clr),
      .match     (matchA),
      .match_cnt (cntA),
      .thr_flag  (flagA)
   );

   moore_seq_detect #(
      .CNT_W  (2),
      .THRESH (THR_B)
   ) u_dutB (
      .clk       (clk),
      .reset     (reset),
      .in_bit    (inBit),
      .in_valid  (inValid),
      .clr       (clr),
      .match     (matchB),
      .match_cnt (cntB),
      .thr_flag  (flagB)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: clear everything, as reset does.
   task automatic modelReset();
      hist     = 4'b0000;
      nValid   = 0;
      expMatch = 1'b0;
      mCntA    = 0;
      mCntB    = 0;
      mFlagA   = 1'b0;
      mFlagB   = 1'b0;
   endtask

   // Model: one rising edge with the given inputs.
   task automatic modelEdge(input logic b, input logic v, input logic c);
      logic hit;
      hit = 1'b0;
      if (v) begin
         hist = {hist[2:0], b};
         if (nValid < 4) nValid++;
         hit      = (nValid >= 4) && (hist == 4'b1011);
         expMatch = hit;
      end
      if (c) begin
         mCntA  = 0;
         mCntB  = 0;
         mFlagA = 1'b0;
         mFlagB = 1'b0;
      end else if (hit) begin
         if (mCntA < MAX_A) begin
            mCntA++;
            if (mCntA == THR_A) mFlagA = 1'b1;
         end
         if (mCntB < MAX_B) begin
            mCntB++;
            if (mCntB == THR_B) mFlagB = 1'b1;
         end
      end
   endtask

   // Compare all outputs of both instances against the model.
   task automatic checkOutput(input string tag);
      logic [7:0] eCntA;
      logic [1:0] eCntB;
      logic       eFlagA;
      logic       eFlagB;
`ifdef MOORE_SEQ_DETECT_CNT_EN
      eCntA  = mCntA[7:0];
      eCntB  = mCntB[1:0];
      eFlagA = mFlagA;
      eFlagB = mFlagB;
`else
      eCntA  = 8'd0;
      eCntB  = 2'd0;
      eFlagA = 1'b0;
      eFlagB = 1'b0;
`endif
      compareCount++;
      assert (matchA === expMatch) else begin
         mismatchCount++;
         $error("[TB] FAIL %s matchA observed=%0b expected=%0b", tag, matchA, expMatch);
      end
      compareCount++;
      assert (matchB === expMatch) else begin
         mismatchCount++;
         $error("[TB] FAIL %s matchB observed=%0b expected=%0b", tag, matchB, expMatch);
      end
      compareCount++;
      assert (cntA === eCntA) else begin
         mismatchCount++;
         $error("[TB] FAIL %s cntA observed=%0d expected=%0d", tag, cntA, eCntA);
      end
      compareCount++;
      assert (cntB === eCntB) else begin
         mismatchCount++;
         $error("[TB] FAIL %s cntB observed=%0d expected=%0d", tag, cntB, eCntB);
      end
      compareCount++;
      assert (flagA === eFlagA) else begin
         mismatchCount++;
         $error("[TB] FAIL %s flagA observed=%0b expected=%0b", tag, flagA, eFlagA);
      end
      compareCount++;
      assert (flagB === eFlagB) else begin
         mismatchCount++;
         $error("[TB] FAIL %s flagB observed=%0b expected=%0b", tag, flagB, eFlagB);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then check 1 after rise.
   task automatic applyStimulus(input logic b, input logic v, input logic c, input string tag);
      @(negedge clk);
      inBit   = b;
      inValid = v;
      clr     = c;
      @(posedge clk);
      modelEdge(b, v, c);
      #1;
      checkOutput(tag);
   endtask

   // Send n valid bits, bit n-1 first.
   task automatic sendBits(input logic [15:0] bits, input int n, input string tag);
      for (int i = n - 1; i >= 0; i--) begin
         applyStimulus(bits[i], 1'b1, 1'b0, tag);
      end
   endtask

   // Pulse reset low mid-cycle, with valid 1s driven, checking asynchronously.
   task automatic pulseReset(input string tag);
      @(negedge clk);
      inBit   = 1'b1;
      inValid = 1'b1;
      clr     = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      modelReset();
      checkOutput({tag, "_async"});
      @(posedge clk);
      #1;
      checkOutput({tag, "_held"});
      @(negedge clk);
      inValid = 1'b0;
      reset   = 1'b1;
   endtask

   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      reset   = 1'b0;
      inBit   = 1'b0;
      inValid = 1'b0;
      clr     = 1'b0;
      modelReset();

      // Reset state
      @(posedge clk);
      #1;
      checkOutput("reset");
      @(negedge clk);
      reset = 1'b1;

      // Single detection, then one trailing bit drops the pulse
      sendBits(16'b1011, 4, "single");
      applyStimulus(1'b0, 1'b1, 1'b0, "singleAfter");

      // Overlapping detection
      pulseReset("rstOverlap");
      sendBits(16'b1011011, 7, "overlap");

      // Gap in the middle of a pattern, then a gap after a detection
      pulseReset("rstGap");
      sendBits(16'b101, 3, "gapPre");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, "gapHold");
      applyStimulus(1'b1, 1'b1, 1'b0, "gapFinal");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, "matchHold");

      // Threshold and saturation over eight back-to-back patterns
      applyStimulus(1'b0, 1'b1, 1'b1, "clrBeforeThr");
      for (int i = 0; i < 8; i++) sendBits(16'b1011, 4, "thresh");

      // Clear together with a match: match pulses, count does not
      sendBits(16'b101, 3, "clrMatchPre");
      applyStimulus(1'b1, 1'b1, 1'b1, "clrWithMatch");
      applyStimulus(1'b0, 1'b0, 1'b0, "clrAfter");

      // Reset mid-pattern discards history
      sendBits(16'b101, 3, "rstMidPre");
      pulseReset("rstMid");
      applyStimulus(1'b1, 1'b1, 1'b0, "rstMidFirst");
      sendBits(16'b011, 3, "rstMidFromS1");

      // Randomized traffic biased towards 1s so matches occur often
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(199) == 0) begin
            pulseReset("randReset");
         end else begin
            applyStimulus(($urandom_range(99) < 60) ? 1'b1 : 1'b0,
                          ($urandom_range(99) < 80) ? 1'b1 : 1'b0,
                          ($urandom_range(99) < 3)  ? 1'b1 : 1'b0,
                          "random");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/moore_seq_detect.md
MOORE_SEQ_DETECT -- requirements
Module: moore_seq_detect

Interface
REQ-001 Parameter CNT_W, default 8: width of the match counter.
REQ-002 Parameter THRESH, default 4: match count at which thr_flag asserts; legal range 1 to 2^CNT_W-1.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous active-low reset; low = reset asserted.
REQ-005 Port in_bit, input, 1: serial bit from the upstream Moore toggle stage (its z output).
REQ-006 Port in_valid, input, 1: in_bit is sampled only when in_valid=1.
REQ-007 Port clr, input, 1: synchronous clear of match_cnt and thr_flag.
REQ-008 Port match, output, 1: Moore output, 1 while the FSM is in state S_1011.
REQ-009 Port match_cnt, output, CNT_W: number of matches since reset or clr.
REQ-010 Port thr_flag, output, 1: sticky flag, set when match_cnt reaches THRESH.

Function
REQ-011 The FSM SHALL detect the overlapping pattern 1,0,1,1 on consecutive valid bits, oldest bit first.
REQ-012 States SHALL be S_IDLE, S_1, S_10, S_101 and S_1011.
REQ-013 Transitions on a valid bit: S_IDLE 1->S_1, 0->S_IDLE; S_1 1->S_1, 0->S_10; S_10 1->S_101, 0->S_IDLE; S_101 1->S_1011, 0->S_10; S_1011 1->S_1, 0->S_10.
REQ-014 With in_valid=0 the state SHALL hold, and match_cnt and thr_flag SHALL hold unless clr=1.
REQ-015 match SHALL be decoded from the state register only, so it is 1 in the cycle after the edge that samples the final 1.
REQ-016 match SHALL stay high for exactly one cycle per detection while valid bits continue to arrive.
REQ-017 match SHALL stay high for as long as in_valid stays 0 after the detection.
REQ-018 match_cnt SHALL increment by 1 on each edge where the FSM moves into S_1011.
REQ-019 match_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-020 thr_flag SHALL set on the edge where match_cnt becomes equal to THRESH.
REQ-021 thr_flag SHALL then stay set, even if match_cnt saturates, until clr or reset.
REQ-022 clr=1 SHALL zero match_cnt and thr_flag on the next edge.
REQ-023 clr SHALL have priority over a simultaneous increment; that match is not counted.
REQ-024 clr SHALL NOT affect the FSM state.

Reset
REQ-025 reset=0 SHALL immediately force the state to S_IDLE, match=0, match_cnt=0 and thr_flag=0, independent of clk.
REQ-026 Reset asserted mid-pattern SHALL discard all partial-pattern history.
REQ-027 The first valid bit after reset release SHALL be evaluated from S_IDLE.

Configuration
REQ-028 Macro MOORE_SEQ_DETECT_CNT_EN defined: match_cnt and thr_flag SHALL behave as in REQ-018 to REQ-024.
REQ-029 Macro MOORE_SEQ_DETECT_CNT_EN undefined: no counter registers SHALL be built; match_cnt and thr_flag SHALL be tied to 0; clr is ignored; FSM and match behaviour are unchanged.

Structure
REQ-030 Package seq_det_pkg SHALL hold the state type, the five state encodings (3-bit binary) and the pattern constant 4'b1011.
REQ-031 The saturating counter plus threshold flag SHALL be sub-module sat_counter.
REQ-032 sat_counter SHALL have parameters CNT_W and THRESH, inputs clk, reset, inc and clr, and outputs cnt and flag.
REQ-033 sat_counter SHALL only be instantiated when MOORE_SEQ_DETECT_CNT_EN is defined.

Verification
REQ-034 Reset, then valid bits 1,0,1,1 -> match=1 for one cycle after the 4th edge; match_cnt=1.
REQ-035 Valid bits 1,0,1,1,0,1,1 -> two match pulses (overlap); match_cnt=2.
REQ-036 Bits 1,0,1 with in_valid dropped for 3 cycles, then 1 -> match=1 one cycle after the final bit; state held during the gap.
REQ-037 Eight back-to-back 1011 patterns with THRESH=4 -> thr_flag set on the edge where match_cnt=4; flag still 1 at match_cnt=8.
REQ-038 With CNT_W=2, five matches -> match_cnt saturates at 3; then clr together with a match -> match_cnt=0 and thr_flag=0.
REQ-039 reset pulsed low after bits 1,0,1, then valid bit 1 -> no match; state S_1; all outputs 0 during reset.
